ccff_chain_loader: RTL
======================

Name: ccff_chain_loader

Overview:
- Sequences the configuration-chain flip-flop scan chain (p_ccff cascades driven by prog_clk) for a tile or fabric.
- Accepts configuration words over a valid/ready stream and shifts them serially into the chain head.
- Gates the chain shift via a clock-enable.
- Supports non-destructive readback: tail bits are captured and recirculated to the head, so the chain contents survive readback.

Parameters:
- CHAIN_LEN, 16, number of p_ccff stages in the chain (>=1).
- DATA_W, 8, configuration word width (>=1).

Ports:
- prog_clk  input  1  programming clock; only clock.
- prog_reset_n  input  1  asynchronous active-low reset.
- start_load  input  1  begin load pass; sampled in IDLE only.
- start_readback  input  1  begin readback pass; sampled in IDLE only.
- abort  input  1  synchronous abort to IDLE.
- in_valid  input  1  config word valid.
- in_data  input  DATA_W  config word.
- in_ready  output  1  word accepted when in_valid & in_ready.
- out_valid  output  1  readback word valid.
- out_data  output  DATA_W  readback word.
- out_ready  input  1  readback word consumed when out_valid & out_ready.
- ccff_head  output  1  serial data to chain input.
- ccff_tail  input  1  chain output (last stage Q).
- ccff_clk_en  output  1  chain shifts on any prog_clk rising edge where this is 1 (external clock gate).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a pass completes.

Behaviour:
- Reset (async, prog_reset_n=0):
  - State goes to IDLE; bit counter, word shift register and out_data go to 0.
  - Outputs in_ready=0, out_valid=0, ccff_clk_en=0, ccff_head=0, busy=0, done=0.
  - Reset mid-pass abandons the pass; the chain holds a partial shift, and no done pulse is generated.
- States: IDLE, LD_FETCH, LD_SHIFT, RB_SHIFT, RB_OUT, DONE.
- IDLE:
  - start_load -> LD_FETCH; bit counter cleared.
  - Else start_readback -> RB_SHIFT.
  - Both asserted together: load wins. Starts are ignored outside IDLE.
- LD_FETCH:
  - in_ready=1 (combinational from state).
  - On handshake: in_data is latched into the shift register, and the state moves to LD_SHIFT on the next cycle.
- LD_SHIFT:
  - ccff_clk_en=1; ccff_head = shift-register MSB.
  - Each cycle: shift left by one, bit counter +1.
  - Leaves after DATA_W bits, or when the counter reaches CHAIN_LEN, whichever comes first:
    - counter == CHAIN_LEN -> DONE;
    - else -> LD_FETCH.
- Load bit order: bit DATA_W-1 of the first word is shifted first and ends in the last stage. Words consumed = ceil(CHAIN_LEN/DATA_W). Unused low bits of the final word are discarded.
- Load throughput: one word per DATA_W+1 cycles when in_valid is held high.
- RB_SHIFT:
  - ccff_clk_en=1; ccff_head = ccff_tail (recirculation).
  - Each cycle ccff_tail is shifted into the capture register LSB, and the counter increments.
  - After DATA_W captures, or when counter == CHAIN_LEN -> RB_OUT.
  - Final partial word is left-justified, with zero-filled low bits.
- RB_OUT:
  - out_valid=1 with the word held stable; ccff_clk_en=0.
  - On handshake: if counter == CHAIN_LEN -> DONE, else -> RB_SHIFT.
  - out_valid may stay high indefinitely; the chain does not move while it does.
- Readback result: after CHAIN_LEN shifts the chain equals its pre-readback contents. The first word MSB is the last-stage bit.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- ccff_clk_en is 0 in every state other than LD_SHIFT and RB_SHIFT. The chain never receives more than CHAIN_LEN shifts per pass.
- ccff_head=0 outside the shift states.
- abort (any non-IDLE state) -> IDLE next cycle:
  - in_ready, out_valid and ccff_clk_en drop immediately after that edge.
  - No done pulse. abort has priority over handshakes in the same cycle.
- Counter width: clog2(CHAIN_LEN+1); no wrap within a pass.

Test Plan:
- CHAIN_LEN=16, DATA_W=8: load 0xA5 then 0x3C with in_valid held -> exactly 16 ccff_clk_en cycles; chain stages 15..0 hold 1010_0101_0011_1100 (stage 15 = first bit); done pulses once at cycle 19 after start.
- Same chain, readback after that load -> out_data 0xA5 then 0x3C; 16 clk_en cycles; a second readback returns identical words.
- CHAIN_LEN=21, DATA_W=8: load 0xFF,0x00,0xE0 -> 21 shifts; 3 words consumed; fourth in_valid word not accepted (in_ready stays 0). Readback -> 0xFF,0x00,0xE0.
- Backpressure: in_valid gaps of 3 cycles, and out_ready low 5 cycles in readback -> ccff_clk_en stays 0 during stalls, and out_data stays stable while out_valid is high.
- start_load and start_readback asserted together in IDLE -> load pass runs; start pulses during busy are ignored.
- abort after 5 load shifts, then async reset asserted mid-readback -> IDLE, all outputs return to reset values, no done pulse; a new full load then succeeds.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - config word input stream and readback word output stream
interface ccff_chain_loader_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial loader / recirculating readback sequencer for a p_ccff scan chain
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 16,
   parameter int DATA_W    = 8
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   input  logic                start_load,
   input  logic                start_readback,
   input  logic                abort,
   ccff_chain_loader_if.slave  bus,
   output logic                ccff_head,
   input  logic                ccff_tail,
   output logic                ccff_clk_en,
   output logic                busy,
   output logic                done
);
   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int WB_W  = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CHAIN_LEN);
   localparam logic [WB_W-1:0]  WB_END  = WB_W'(DATA_W);

   typedef enum logic [2:0] {
      IDLE, LD_FETCH, LD_SHIFT, RB_SHIFT, RB_OUT, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WB_W-1:0]   word_bits;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] out_data_q;

   logic [CNT_W-1:0]  bit_cnt_inc;
   logic [WB_W-1:0]   word_bits_inc;
   logic [DATA_W-1:0] capture;
   logic              chain_end;
   logic              word_end;

   assign bit_cnt_inc   = bit_cnt + CNT_W'(1);
   assign word_bits_inc = word_bits + WB_W'(1);
   assign chain_end     = (bit_cnt_inc == CNT_END);
   assign word_end      = (word_bits_inc == WB_END);
   assign capture       = (shreg << 1) | DATA_W'(ccff_tail);

   assign busy         = (state != IDLE);
   assign bus.out_data = out_data_q;

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      ccff_clk_en  = 1'b0;
      ccff_head    = 1'b0;
      done         = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_load) begin
               state_nxt = LD_FETCH;
            end else if (start_readback) begin
               state_nxt = RB_SHIFT;
            end
         end
         LD_FETCH: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = LD_SHIFT;
            end
         end
         LD_SHIFT: begin
            ccff_clk_en = 1'b1;
            ccff_head   = shreg[DATA_W-1];
            if (chain_end) begin
               state_nxt = DONE;
            end else if (word_end) begin
               state_nxt = LD_FETCH;
            end
         end
         RB_SHIFT: begin
            // Tail bit goes straight back into the head so readback is non-destructive
            ccff_clk_en = 1'b1;
            ccff_head   = ccff_tail;
            if (chain_end || word_end) begin
               state_nxt = RB_OUT;
            end
         end
         RB_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = (bit_cnt == CNT_END) ? DONE : RB_SHIFT;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         bit_cnt    <= '0;
         word_bits  <= '0;
         shreg      <= '0;
         out_data_q <= '0;
      end else if (!abort || (state == IDLE)) begin
         unique case (state)
            IDLE: begin
               if (start_load || start_readback) begin
                  bit_cnt   <= '0;
                  word_bits <= '0;
                  shreg     <= '0;
               end
            end
            LD_FETCH: begin
               if (bus.in_valid) begin
                  shreg     <= bus.in_data;
                  word_bits <= '0;
               end
            end
            LD_SHIFT: begin
               shreg     <= shreg << 1;
               bit_cnt   <= bit_cnt_inc;
               word_bits <= word_bits_inc;
            end
            RB_SHIFT: begin
               shreg     <= capture;
               bit_cnt   <= bit_cnt_inc;
               word_bits <= word_bits_inc;
               // A short final word is left-justified with zero fill
               if (chain_end || word_end) begin
                  out_data_q <= capture << (WB_END - word_bits_inc);
               end
            end
            RB_OUT: begin
               if (bus.out_ready) begin
                  word_bits <= '0;
                  shreg     <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
